// File: rtl/branch_pkg.sv
// Shared definitions for the branch prediction unit: branch codes,
// two-bit counter states, the default PC width and the counter step rule.
package branch_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_BLTU = 3'b101,
        BR_BGEU = 3'b110,
        BR_JUMP = 3'b111
    } br_code_e;

    // Two-bit saturating counter states; the MSB is the taken prediction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // One step of the saturating counter towards taken (up=1) or not taken.
    function automatic logic [1:0] sat_step(input logic [1:0] state, input logic up);
        logic [1:0] next;
        next = state;
        if (up && state != ST) begin
            next = state + 2'd1;
        end else if (!up && state != SNT) begin
            next = state - 2'd1;
        end
        return next;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Resolve-stage decode: branch outcome and PC-mux selects from the ALU flags.
module branch_cond
    import branch_pkg::*;
(
    input  logic       valid_i,
    input  logic [2:0] branch_i,
    input  logic       jumps_i,
    input  logic       zero_i,
    input  logic       less_i,
    output logic       taken_o,
    output logic       cond_o,
    output logic       pcasrc_o,
    output logic       pcbsrc_o
);

    br_code_e code;
    assign code = br_code_e'(branch_i);

    // Decode the branch outcome and steer the PC muxes.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        taken_o  = 1'b0;
        cond_o   = 1'b0;
        pcasrc_o = 1'b1;
        pcbsrc_o = 1'b0;
        if (valid_i) begin
            case (code)
                BR_BEQ:           begin cond_o = 1'b1; taken_o = zero_i;  end
                BR_BNE:           begin cond_o = 1'b1; taken_o = ~zero_i; end
                BR_BLT, BR_BLTU:  begin cond_o = 1'b1; taken_o = less_i;  end
                BR_BGE, BR_BGEU:  begin cond_o = 1'b1; taken_o = ~less_i; end
                BR_JUMP: begin
                    taken_o  = 1'b1;
                    pcasrc_o = 1'b0;
                    pcbsrc_o = ~jumps_i;   // JALR takes the register-based source
                end
                default: ;
            endcase
            if (cond_o && taken_o) begin
                pcasrc_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of two-bit saturating counters indexed
// by PC, resolve-stage training, mispredict flush/redirect and perf counters.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int         XLEN        = XLEN_DEFAULT,
    parameter int         BHT_ENTRIES = 64,
    parameter int         CNT_W       = 32,
    parameter logic [1:0] INIT_STATE  = WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pred_pc_i,
    output logic             pred_taken_o,
    input  logic             res_valid_i,
    input  logic [XLEN-1:0]  res_pc_i,
    input  logic [2:0]       res_branch_i,
    input  logic             res_jumps_i,
    input  logic             res_zero_i,
    input  logic             res_less_i,
    input  logic             res_pred_taken_i,
    input  logic [XLEN-1:0]  res_target_i,
    output logic             pcasrc_o,
    output logic             pcbsrc_o,
    output logic             flush_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d;
    logic             bht_we;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;

    logic             rst_guard_q;   // high during reset and the first edge after release
    logic             taken;
    logic             is_cond;
    logic             accept;
    logic             is_branch;
    logic             mispredict;

    logic             flush_q;
    logic [XLEN-1:0]  redirect_q, redirect_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // PC bits outside the index field do not affect the prediction.
    logic unused_pred_bits;
    assign unused_pred_bits = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0]};

    branch_cond u_cond (
        .valid_i  (res_valid_i),
        .branch_i (res_branch_i),
        .jumps_i  (res_jumps_i),
        .zero_i   (res_zero_i),
        .less_i   (res_less_i),
        .taken_o  (taken),
        .cond_o   (is_cond),
        .pcasrc_o (pcasrc_o),
        .pcbsrc_o (pcbsrc_o)
    );

    assign pred_idx     = pred_pc_i[IDX_W+1:2];
    assign res_idx      = res_pc_i[IDX_W+1:2];
    assign pred_taken_o = bht_q[pred_idx][1];   // no bypass of a same-cycle update

    assign accept     = res_valid_i & ~rst_guard_q;
    assign is_branch  = accept & (br_code_e'(res_branch_i) != BR_NONE);
    assign mispredict = is_branch & (taken != res_pred_taken_i);
    assign bht_we     = accept & is_cond;
    assign bht_d      = sat_step(bht_q[res_idx], taken);

    // Next redirect target and saturating performance counts.
    always_comb begin
        redirect_d    = redirect_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (mispredict) begin
            redirect_d = taken ? res_target_i : res_pc_i + XLEN'(4);
        end
        if (is_branch && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispredict && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    // Suppress any resolve on the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (rst) begin
            rst_guard_q <= 1'b1;
        end else begin
            rst_guard_q <= 1'b0;
        end
    end

    // Flush pulse, redirect PC and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            flush_q       <= mispredict;
            redirect_q    <= redirect_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Branch history table training.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the table must come out of reset in a known state, so it is
        // a flop array with a reset loop rather than an inferred RAM.
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= INIT_STATE;
            end
        end else if (bht_we) begin
            bht_q[res_idx] <= bht_d;
        end
    end

    assign flush_o       = flush_q;
    assign redirect_pc_o = redirect_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit with a behavioural reference model.
module tb_branch_predict_unit;

    localparam int         XLEN    = 32;
    localparam int         ENTRIES = 16;
    localparam int         CNT_W   = 4;
    localparam logic [1:0] INIT    = 2'b01;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [XLEN-1:0]  pred_pc_i = '0;
    logic             pred_taken_o;
    logic             res_valid_i = 1'b0;
    logic [XLEN-1:0]  res_pc_i = '0;
    logic [2:0]       res_branch_i = '0;
    logic             res_jumps_i = 1'b0;
    logic             res_zero_i = 1'b0;
    logic             res_less_i = 1'b0;
    logic             res_pred_taken_i = 1'b0;
    logic [XLEN-1:0]  res_target_i = '0;
    logic             pcasrc_o, pcbsrc_o, flush_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic [CNT_W-1:0] branch_cnt_o, mispred_cnt_o;

    branch_predict_unit #(
        .XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .CNT_W(CNT_W), .INIT_STATE(INIT)
    ) dut (
        .clk(clk), .rst(rst),
        .pred_pc_i(pred_pc_i), .pred_taken_o(pred_taken_o),
        .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_branch_i(res_branch_i),
        .res_jumps_i(res_jumps_i), .res_zero_i(res_zero_i), .res_less_i(res_less_i),
        .res_pred_taken_i(res_pred_taken_i), .res_target_i(res_target_i),
        .pcasrc_o(pcasrc_o), .pcbsrc_o(pcbsrc_o), .flush_o(flush_o),
        .redirect_pc_o(redirect_pc_o), .branch_cnt_o(branch_cnt_o),
        .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct { bit flush; logic [XLEN-1:0] redir; int bc; int mc; } reg_exp_t;
    typedef struct { bit pa; bit pb; bit pt; } comb_exp_t;

    reg_exp_t  reg_q[$];
    comb_exp_t comb_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    int              bht_m [ENTRIES];
    logic [XLEN-1:0] redir_m;
    int              bc_m, mc_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit ref_taken(input bit v, input int br, input bit z, input bit l);
        if (!v) return 1'b0;
        case (br)
            1:       return z;
            2:       return !z;
            3, 5:    return l;
            4, 6:    return !l;
            7:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) bht_m[i] = int'(INIT);
        redir_m = '0;
        bc_m = 0;
        mc_m = 0;
    endfunction

    // One resolve cycle, driven at the falling edge; returns at the next falling edge.
    task automatic cycle(input bit v, input int br, input bit j, input bit z, input bit l,
                         input bit p, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                         input logic [XLEN-1:0] ppc, input bit discard);
        comb_exp_t c;
        reg_exp_t  r;
        bit t, mis;
        res_valid_i = v; res_branch_i = 3'(br); res_jumps_i = j; res_zero_i = z;
        res_less_i = l; res_pred_taken_i = p; res_pc_i = pc; res_target_i = tgt;
        pred_pc_i = ppc;
        t = ref_taken(v, br, z, l);
        c.pt = (bht_m[idx_of(ppc)] >= 2);
        c.pa = 1'b1; c.pb = 1'b0;
        if (v && br == 7) begin
            c.pa = 1'b0; c.pb = !j;
        end else if (v && br >= 1 && br <= 6 && t) begin
            c.pa = 1'b0;
        end
        comb_q.push_back(c);
        mis = 1'b0;
        if (v && !discard && br != 0) begin
            if (bc_m < CNT_MAX) bc_m++;
            mis = (t != p);
            if (mis) begin
                if (mc_m < CNT_MAX) mc_m++;
                redir_m = t ? tgt : pc + 32'd4;
            end
            if (br <= 6) begin
                if (t) bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] == 3) ? 3 : bht_m[idx_of(pc)] + 1;
                else   bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] == 0) ? 0 : bht_m[idx_of(pc)] - 1;
            end
        end
        r.flush = mis; r.redir = redir_m; r.bc = bc_m; r.mc = mc_m;
        reg_q.push_back(r);
        @(negedge clk);
    endtask

    task automatic idle(input logic [XLEN-1:0] ppc);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ppc, 1'b0);
    endtask

    // Asynchronous reset pulse with immediate checks, released at a falling edge.
    task automatic do_reset();
        logic [XLEN-1:0] pc;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("rst_flush", 64'(flush_o), 64'(0));
        check("rst_redirect", 64'(redirect_pc_o), 64'(0));
        check("rst_branch_cnt", 64'(branch_cnt_o), 64'(0));
        check("rst_mispred_cnt", 64'(mispred_cnt_o), 64'(0));
        for (int i = 0; i < ENTRIES; i++) begin
            pc = ($urandom() * ENTRIES * 4) + 32'(i * 4) + 32'($urandom_range(0, 3));
            pred_pc_i = pc;
            #1 check("rst_pred", 64'(pred_taken_o), 64'(INIT[1]));
        end
        @(negedge clk);
        rst = 1'b0;
        // First edge after release: a mispredicting resolve that must be ignored.
        cycle(1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h4000, 32'h100, 1'b1);
    endtask

    // Registered-output monitor: one expectation per clock edge.
    initial begin
        reg_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                check("flush", 64'(flush_o), 64'(e.flush));
                check("redirect", 64'(redirect_pc_o), 64'(e.redir));
                check("branch_cnt", 64'(branch_cnt_o), 64'(e.bc));
                check("mispred_cnt", 64'(mispred_cnt_o), 64'(e.mc));
            end
        end
    end

    // Combinational-output monitor: checked mid low phase after inputs settle.
    initial begin
        comb_exp_t c;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                check("pcasrc", 64'(pcasrc_o), 64'(c.pa));
                check("pcbsrc", 64'(pcbsrc_o), 64'(c.pb));
                check("pred_taken", 64'(pred_taken_o), 64'(c.pt));
            end
        end
    end

    initial begin
        logic [XLEN-1:0] pc, ppc;
        int br;
        bit p;
        do_reset();

        // BLT not taken at the top of the address space, predicted taken: wraps to 0.
        cycle(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h800, 32'h100, 1'b0);
        check("wrap_redirect_expect", 64'(redir_m), 64'(0));
        // BEQ taken at 0x100, predicted not taken.
        cycle(1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h2000, 32'h100, 1'b0);
        idle(32'h100);

        // Five taken then one not taken at 0x240.
        for (int k = 0; k < 5; k++)
            cycle(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h240, 32'h300, 32'h240, 1'b0);
        cycle(1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h240, 32'h300, 32'h240, 1'b0);
        idle(32'h240);

        // JALR mispredicted, then JAL correctly predicted.
        cycle(1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h180, 32'h9000, 32'h180, 1'b0);
        cycle(1'b1, 7, 1'b1, 1'b1, 1'b1, 1'b1, 32'h180, 32'hA000, 32'h180, 1'b0);
        idle(32'h180);

        // Back-to-back mispredicts, then reset mid-stream.
        cycle(1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h88, 32'h44, 1'b0);
        cycle(1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h5000, 32'h100, 1'b0);
        do_reset();

        // Randomized traffic over a small, aliasing PC pool.
        for (int n = 0; n < 400; n++) begin
            pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 47) * 4);
            ppc = ($urandom_range(0, 3) == 0) ? pc : 32'($urandom_range(0, 63) * 4);
            br  = $urandom_range(0, 7);
            p   = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : (bht_m[idx_of(pc)] >= 2);
            cycle(($urandom_range(0, 4) != 0), br, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p,
                  pc, $urandom(), ppc, 1'b0);
            if (n == 200) do_reset();
        end
        idle('0);

        for (int k = 0; k < 10 && (reg_q.size() > 0 || comb_q.size() > 0); k++) @(negedge clk);
        check("drain_reg", 64'(reg_q.size()), 64'(0));
        check("drain_comb", 64'(comb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
